// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one data-cache port between two requesters; 0-cycle added latency on hits.
// Backpressure via reqX_miss: a missed access locks the grant and replays the captured request until done.
module cache_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req0_re,
    input  logic              req0_we,
    output logic [DATA_W-1:0] req0_rdata,
    output logic              req0_miss,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    input  logic              req1_re,
    input  logic              req1_we,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              req1_miss,
    output logic [ADDR_W-1:0] addr_cache,
    output logic [DATA_W-1:0] wdata_cache,
    output logic              read_enable_cache,
    output logic              write_enable_cache,
    input  logic [DATA_W-1:0] rdata_cache,
    input  logic              miss_cache,
    output logic              owner,
    output logic [CNT_W-1:0]  stall_cnt0,
    output logic [CNT_W-1:0]  stall_cnt1
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic              locked;
    logic              owner_q;
    logic              last;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;
    logic              cap_re;
    logic              cap_we;

    logic req0, req1, any_req, g;

    assign req0    = req0_re | req0_we;
    assign req1    = req1_re | req1_we;
    assign any_req = req0 | req1;
    assign g       = (req0 && req1) ? ~last : req1;

    assign req0_rdata = rdata_cache;
    assign req1_rdata = rdata_cache;

    always_comb begin
        addr_cache         = '0;
        wdata_cache        = '0;
        read_enable_cache  = 1'b0;
        write_enable_cache = 1'b0;
        req0_miss          = req0;
        req1_miss          = req1;
        owner              = owner_q;
        if (rst) begin
            req0_miss = 1'b1;
            req1_miss = 1'b1;
        end else if (locked) begin
            addr_cache         = cap_addr;
            wdata_cache        = cap_wdata;
            read_enable_cache  = cap_re;
            write_enable_cache = cap_we;
            if (owner_q) req1_miss = miss_cache;
            else         req0_miss = miss_cache;
        end else if (any_req) begin
            owner = g;
            if (g) begin
                addr_cache         = req1_addr;
                wdata_cache        = req1_wdata;
                read_enable_cache  = req1_re & ~req1_we;
                write_enable_cache = req1_we;
                req1_miss          = miss_cache;
            end else begin
                addr_cache         = req0_addr;
                wdata_cache        = req0_wdata;
                read_enable_cache  = req0_re & ~req0_we;
                write_enable_cache = req0_we;
                req0_miss          = miss_cache;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            locked     <= 1'b0;
            owner_q    <= 1'b0;
            last       <= 1'b1;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            cap_re     <= 1'b0;
            cap_we     <= 1'b0;
            stall_cnt0 <= '0;
            stall_cnt1 <= '0;
        end else begin
            if (locked) begin
                // Completion of the replayed access releases the port even if the requester left.
                if (!miss_cache) begin
                    locked <= 1'b0;
                    last   <= owner_q;
                end
            end else if (any_req) begin
                owner_q <= g;
                if (miss_cache) begin
                    locked    <= 1'b1;
                    cap_addr  <= addr_cache;
                    cap_wdata <= wdata_cache;
                    cap_re    <= read_enable_cache;
                    cap_we    <= write_enable_cache;
                end else begin
                    last <= g;
                end
            end
            if (req0 && req0_miss && stall_cnt0 != '1) stall_cnt0 <= stall_cnt0 + CNT_ONE;
            if (req1 && req1_miss && stall_cnt1 != '1) stall_cnt1 <= stall_cnt1 + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter; counters narrowed to 3 bits so saturation is reachable.
module tb_cache_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] req0_addr, req0_wdata, req0_rdata;
    logic        req0_re, req0_we, req0_miss;
    logic [31:0] req1_addr, req1_wdata, req1_rdata;
    logic        req1_re, req1_we, req1_miss;
    logic [31:0] addr_cache, wdata_cache, rdata_cache;
    logic        read_enable_cache, write_enable_cache, miss_cache, owner;
    logic [2:0]  stall_cnt0, stall_cnt1;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    cache_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_re(req0_re), .req0_we(req0_we),
        .req0_rdata(req0_rdata), .req0_miss(req0_miss),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_re(req1_re), .req1_we(req1_we),
        .req1_rdata(req1_rdata), .req1_miss(req1_miss),
        .addr_cache(addr_cache), .wdata_cache(wdata_cache),
        .read_enable_cache(read_enable_cache), .write_enable_cache(write_enable_cache),
        .rdata_cache(rdata_cache), .miss_cache(miss_cache), .owner(owner),
        .stall_cnt0(stall_cnt0), .stall_cnt1(stall_cnt1)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_addr = '0; req0_wdata = '0; req0_re = 0; req0_we = 0;
        req1_addr = '0; req1_wdata = '0; req1_re = 0; req1_we = 0;
        rdata_cache = '0; miss_cache = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        cyc();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++; if (read_enable_cache !== 1'b0 || write_enable_cache !== 1'b0) $display("FAIL reset_en re=%b we=%b exp 0/0", read_enable_cache, write_enable_cache); else passed++;
        total++; if (stall_cnt0 !== 3'd0 || stall_cnt1 !== 3'd0) $display("FAIL reset_cnt c0=%0d c1=%0d exp 0/0", stall_cnt0, stall_cnt1); else passed++;
        total++; if (owner !== 1'b0) $display("FAIL reset_owner got %b exp 0", owner); else passed++;
    endtask

    task automatic test_single_read();
        do_reset();
        req0_re = 1; req0_addr = 32'h100; rdata_cache = 32'h1234_5678;
        #1;
        total++; if (read_enable_cache !== 1'b1 || addr_cache !== 32'h100) $display("FAIL single_rd re=%b addr=%h exp 1/100", read_enable_cache, addr_cache); else passed++;
        total++; if (req0_miss !== 1'b0) $display("FAIL single_miss got %b exp 0", req0_miss); else passed++;
        total++; if (req0_rdata !== 32'h1234_5678) $display("FAIL single_rdata got %h exp 12345678", req0_rdata); else passed++;
        cyc();
        total++; if (stall_cnt0 !== 3'd0) $display("FAIL single_cnt got %0d exp 0", stall_cnt0); else passed++;
    endtask

    task automatic test_round_robin();
        do_reset();
        req0_re = 1; req0_addr = 32'h10; req1_re = 1; req1_addr = 32'h20;
        #1;
        total++; if (owner !== 1'b0 || addr_cache !== 32'h10 || req1_miss !== 1'b1) $display("FAIL rr_c1 owner=%b addr=%h m1=%b exp 0/10/1", owner, addr_cache, req1_miss); else passed++;
        cyc();
        total++; if (owner !== 1'b1 || addr_cache !== 32'h20 || req0_miss !== 1'b1 || req1_miss !== 1'b0) $display("FAIL rr_c2 owner=%b addr=%h m0=%b m1=%b exp 1/20/1/0", owner, addr_cache, req0_miss, req1_miss); else passed++;
        cyc();
        total++; if (stall_cnt1 !== 3'd1 || stall_cnt0 !== 3'd1) $display("FAIL rr_cnt c0=%0d c1=%0d exp 1/1", stall_cnt0, stall_cnt1); else passed++;
        total++; if (owner !== 1'b0 || addr_cache !== 32'h10) $display("FAIL rr_c3 owner=%b addr=%h exp 0/10", owner, addr_cache); else passed++;
    endtask

    task automatic test_locked_miss();
        do_reset();
        // Port 0 hits alone first so the tie that follows goes to port 1.
        req0_re = 1; req0_addr = 32'h80;
        cyc();
        req1_we = 1; req1_addr = 32'h40; req1_wdata = 32'hDEAD_BEEF; miss_cache = 1;
        for (int c = 1; c <= 4; c++) begin
            if (c == 2) req1_addr = 32'h44;
            if (c == 4) miss_cache = 0;
            #1;
            total++; if (addr_cache !== 32'h40 || wdata_cache !== 32'hDEAD_BEEF || write_enable_cache !== 1'b1) $display("FAIL lock_c%0d addr=%h wd=%h we=%b exp 40/deadbeef/1", c, addr_cache, wdata_cache, write_enable_cache); else passed++;
            total++; if (req0_miss !== 1'b1) $display("FAIL lock_m0_c%0d got %b exp 1", c, req0_miss); else passed++;
            cyc();
        end
        total++; if (stall_cnt0 !== 3'd4 || stall_cnt1 !== 3'd3) $display("FAIL lock_cnt c0=%0d c1=%0d exp 4/3", stall_cnt0, stall_cnt1); else passed++;
        req1_we = 0;
        #1;
        total++; if (owner !== 1'b0 || addr_cache !== 32'h80 || req0_miss !== 1'b0) $display("FAIL lock_c5 owner=%b addr=%h m0=%b exp 0/80/0", owner, addr_cache, req0_miss); else passed++;
    endtask

    task automatic test_drop_while_locked();
        do_reset();
        req0_re = 1; req0_addr = 32'h300; miss_cache = 1;
        cyc();
        req0_re = 0; req0_addr = 32'h999;
        #1;
        total++; if (read_enable_cache !== 1'b1 || addr_cache !== 32'h300) $display("FAIL drop_replay re=%b addr=%h exp 1/300", read_enable_cache, addr_cache); else passed++;
        miss_cache = 0;
        cyc();
        #1;
        total++; if (read_enable_cache !== 1'b0 || stall_cnt0 !== 3'd1) $display("FAIL drop_done re=%b c0=%0d exp 0/1", read_enable_cache, stall_cnt0); else passed++;
    endtask

    task automatic test_write_priority();
        do_reset();
        req0_re = 1; req0_we = 1; req0_addr = 32'h8;
        #1;
        total++; if (write_enable_cache !== 1'b1 || read_enable_cache !== 1'b0 || addr_cache !== 32'h8) $display("FAIL rw_both we=%b re=%b addr=%h exp 1/0/8", write_enable_cache, read_enable_cache, addr_cache); else passed++;
    endtask

    task automatic test_reset_mid_miss();
        do_reset();
        req0_re = 1; req0_addr = 32'h200; miss_cache = 1;
        cyc();
        rst = 1;
        #1;
        total++; if (read_enable_cache !== 1'b0 || req0_miss !== 1'b1 || req1_miss !== 1'b1) $display("FAIL rstmid_out re=%b m0=%b m1=%b exp 0/1/1", read_enable_cache, req0_miss, req1_miss); else passed++;
        cyc();
        rst = 0; idle_inputs();
        #1;
        total++; if (read_enable_cache !== 1'b0 || write_enable_cache !== 1'b0 || stall_cnt0 !== 3'd0) $display("FAIL rstmid_idle re=%b we=%b c0=%0d exp 0/0/0", read_enable_cache, write_enable_cache, stall_cnt0); else passed++;
        req0_re = 1; req0_addr = 32'h10; req1_re = 1; req1_addr = 32'h20;
        #1;
        total++; if (owner !== 1'b0 || addr_cache !== 32'h10 || req0_miss !== 1'b0) $display("FAIL rstmid_tie owner=%b addr=%h m0=%b exp 0/10/0", owner, addr_cache, req0_miss); else passed++;
    endtask

    task automatic test_saturation();
        do_reset();
        req0_re = 1; req0_addr = 32'h50; miss_cache = 1;
        repeat (6) cyc();
        total++; if (stall_cnt0 !== 3'd6) $display("FAIL sat_pre got %0d exp 6", stall_cnt0); else passed++;
        for (int c = 1; c <= 3; c++) begin
            cyc();
            total++; if (stall_cnt0 !== 3'd7) $display("FAIL sat_c%0d got %0d exp 7", c, stall_cnt0); else passed++;
        end
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_locked_miss();
        test_drop_while_locked();
        test_write_priority();
        test_reset_mid_miss();
        test_saturation();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
